// File: rtl/map_table.sv
// ---------------------------------------------------------------------------
// map_table
//   Register alias table for an out-of-order core. Each architectural
//   register owns one entry {rdy, tag}. The tag is the physical register that
//   currently holds the value. The rdy bit is set once that physical register
//   has been written back on the CDB.
//
// Ports
//   clk, rst             : clock; synchronous active-high reset
//   rename_vld_i         : dispatch renames dest_idx_i to new_tag_i this cycle
//   dest_idx_i           : architectural destination being renamed
//   new_tag_i            : physical tag taken from the free list
//   src1_idx_i/src2_idx_i: architectural sources to look up
//   src1_tag_o/src2_tag_o: current physical mapping of each source
//   src1_rdy_o/src2_rdy_o: source value available (includes same-cycle CDB hit)
//   old_tag_o            : previous mapping of dest_idx_i, released at retire
//   cdb_vld_i, cdb_tag_i : completion broadcast
//   br_state_i           : branch resolution; `BR_PR_WRONG restores a snapshot
//   rc_mt_all_data_i     : snapshot image from the branch stack
//   bak_mp_next_data_o   : image the table will hold after this edge, used as
//                          the checkpoint for a branch dispatched this cycle
//
// Image packing: entry i occupies bits [i*(PRF_IDX_W+1) +: PRF_IDX_W+1].
// ---------------------------------------------------------------------------
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b11
`endif

module map_table #(
    parameter int MT_NUM     = 32,
    parameter int PRF_IDX_W  = 6,
    parameter int BR_STATE_W = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rename_vld_i,
    input  logic [$clog2(MT_NUM)-1:0]           dest_idx_i,
    input  logic [PRF_IDX_W-1:0]                new_tag_i,
    input  logic [$clog2(MT_NUM)-1:0]           src1_idx_i,
    input  logic [$clog2(MT_NUM)-1:0]           src2_idx_i,
    output logic [PRF_IDX_W-1:0]                src1_tag_o,
    output logic [PRF_IDX_W-1:0]                src2_tag_o,
    output logic                                src1_rdy_o,
    output logic                                src2_rdy_o,
    output logic [PRF_IDX_W-1:0]                old_tag_o,
    input  logic                                cdb_vld_i,
    input  logic [PRF_IDX_W-1:0]                cdb_tag_i,
    input  logic [BR_STATE_W-1:0]               br_state_i,
    input  logic [MT_NUM*(PRF_IDX_W+1)-1:0]     rc_mt_all_data_i,
    output logic [MT_NUM*(PRF_IDX_W+1)-1:0]     bak_mp_next_data_o
);

    localparam int IDX_W = $clog2(MT_NUM);
    localparam int ENT_W = PRF_IDX_W + 1;

    logic [ENT_W-1:0] table_q [MT_NUM];
    logic [ENT_W-1:0] table_d [MT_NUM];   // next table ignoring reset
    logic             mispredict;

    logic [ENT_W-1:0] src1_ent;
    logic [ENT_W-1:0] src2_ent;
    logic [ENT_W-1:0] old_ent;
    logic             src1_ok;
    logic             src2_ok;
    logic             dest_ok;

    // Only matters when MT_NUM is not a power of two.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < (IDX_W+1)'(MT_NUM));
    endfunction

    // Identity mapping, ready: architectural register i lives in physical i.
    function automatic logic [ENT_W-1:0] reset_ent(input int i);
        return {1'b1, PRF_IDX_W'(i)};
    endfunction

    // Entry is ready if already marked, or its producer is on the CDB now.
    function automatic logic fwd_rdy(input logic [ENT_W-1:0] ent,
                                     input logic             vld,
                                     input logic [PRF_IDX_W-1:0] tag);
        return ent[PRF_IDX_W] | (vld && (ent[PRF_IDX_W-1:0] == tag));
    endfunction

    assign mispredict = (br_state_i == BR_STATE_W'(`BR_PR_WRONG));

    assign src1_ok = idx_ok(src1_idx_i);
    assign src2_ok = idx_ok(src2_idx_i);
    assign dest_ok = idx_ok(dest_idx_i);

    // Reads come from the registered table, so a source that matches this
    // cycle's destination still sees the pre-rename mapping.
    assign src1_ent = src1_ok ? table_q[src1_idx_i] : '0;
    assign src2_ent = src2_ok ? table_q[src2_idx_i] : '0;
    assign old_ent  = dest_ok ? table_q[dest_idx_i] : '0;

    assign src1_tag_o = src1_ent[PRF_IDX_W-1:0];
    assign src2_tag_o = src2_ent[PRF_IDX_W-1:0];
    assign old_tag_o  = old_ent[PRF_IDX_W-1:0];
    assign src1_rdy_o = src1_ok && fwd_rdy(src1_ent, cdb_vld_i, cdb_tag_i);
    assign src2_rdy_o = src2_ok && fwd_rdy(src2_ent, cdb_vld_i, cdb_tag_i);

    // Next-state table. On a mispredict the snapshot replaces the table but
    // the CDB still marks loaded entries ready; otherwise the snapshot is
    // unused. The rename is applied last so it overrides a CDB hit on the
    // same entry, and it is dropped entirely on a mispredict.
    always_comb begin
        for (int i = 0; i < MT_NUM; i++) begin
            table_d[i] = mispredict ? rc_mt_all_data_i[i*ENT_W +: ENT_W]
                                    : table_q[i];
            if (cdb_vld_i && (table_d[i][PRF_IDX_W-1:0] == cdb_tag_i)) begin
                table_d[i][PRF_IDX_W] = 1'b1;
            end
            if (!mispredict && rename_vld_i && dest_ok &&
                (dest_idx_i == IDX_W'(i))) begin
                table_d[i] = {1'b0, new_tag_i};
            end
        end
    end

    // Checkpoint image must match what the register will load, reset included.
    always_comb begin
        bak_mp_next_data_o = '0;
        for (int i = 0; i < MT_NUM; i++) begin
            bak_mp_next_data_o[i*ENT_W +: ENT_W] = rst ? reset_ent(i) : table_d[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MT_NUM; i++) begin
            if (rst) begin
                table_q[i] <= reset_ent(i);
            end else begin
                table_q[i] <= table_d[i];
            end
        end
    end

endmodule

// File: tb/tb_map_table.sv
// ---------------------------------------------------------------------------
// tb_map_table
//   Self-checking bench for map_table: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   behavioural table model.
// ---------------------------------------------------------------------------
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b11
`endif

module tb_map_table;

    localparam int N  = 32;
    localparam int TW = 6;
    localparam int EW = TW + 1;
    localparam int BW = 2;
    localparam int IW = 5;
    localparam logic [BW-1:0] WRONG = `BR_PR_WRONG;

    logic            clk = 1'b0;
    logic            rst;
    logic            rename_vld_i;
    logic [IW-1:0]   dest_idx_i;
    logic [TW-1:0]   new_tag_i;
    logic [IW-1:0]   src1_idx_i;
    logic [IW-1:0]   src2_idx_i;
    logic [TW-1:0]   src1_tag_o;
    logic [TW-1:0]   src2_tag_o;
    logic            src1_rdy_o;
    logic            src2_rdy_o;
    logic [TW-1:0]   old_tag_o;
    logic            cdb_vld_i;
    logic [TW-1:0]   cdb_tag_i;
    logic [BW-1:0]   br_state_i;
    logic [N*EW-1:0] rc_mt_all_data_i;
    logic [N*EW-1:0] bak_mp_next_data_o;

    map_table #(.MT_NUM(N), .PRF_IDX_W(TW), .BR_STATE_W(BW)) dut (
        .clk                (clk),
        .rst                (rst),
        .rename_vld_i       (rename_vld_i),
        .dest_idx_i         (dest_idx_i),
        .new_tag_i          (new_tag_i),
        .src1_idx_i         (src1_idx_i),
        .src2_idx_i         (src2_idx_i),
        .src1_tag_o         (src1_tag_o),
        .src2_tag_o         (src2_tag_o),
        .src1_rdy_o         (src1_rdy_o),
        .src2_rdy_o         (src2_rdy_o),
        .old_tag_o          (old_tag_o),
        .cdb_vld_i          (cdb_vld_i),
        .cdb_tag_i          (cdb_tag_i),
        .br_state_i         (br_state_i),
        .rc_mt_all_data_i   (rc_mt_all_data_i),
        .bak_mp_next_data_o (bak_mp_next_data_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: the table as arrays of tags and ready flags.
    logic [TW-1:0] m_tag [N];
    logic          m_rdy [N];
    bit            m_valid = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*EW-1:0] ident_image();
        logic [N*EW-1:0] img;
        img = '0;
        for (int i = 0; i < N; i++) img[i*EW +: EW] = {1'b1, TW'(i)};
        return img;
    endfunction

    // Compare process: outputs from the model's current table, then the
    // model's next table against the checkpoint image, then commit.
    always @(negedge clk) begin
        logic [TW-1:0]   n_tag [N];
        logic            n_rdy [N];
        logic [N*EW-1:0] exp_bak;
        if (m_valid) begin
            chk("src1_tag", src1_tag_o, m_tag[src1_idx_i]);
            chk("src1_rdy", src1_rdy_o,
                m_rdy[src1_idx_i] | (cdb_vld_i && cdb_tag_i == m_tag[src1_idx_i]));
            chk("src2_tag", src2_tag_o, m_tag[src2_idx_i]);
            chk("src2_rdy", src2_rdy_o,
                m_rdy[src2_idx_i] | (cdb_vld_i && cdb_tag_i == m_tag[src2_idx_i]));
            chk("old_tag", old_tag_o, m_tag[dest_idx_i]);
        end
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                n_tag[i] = TW'(i);
                n_rdy[i] = 1'b1;
            end else if (br_state_i == WRONG) begin
                n_tag[i] = rc_mt_all_data_i[i*EW +: TW];
                n_rdy[i] = rc_mt_all_data_i[i*EW + TW];
            end else begin
                n_tag[i] = m_tag[i];
                n_rdy[i] = m_rdy[i];
            end
            if (!rst && cdb_vld_i && n_tag[i] == cdb_tag_i) n_rdy[i] = 1'b1;
        end
        if (!rst && br_state_i != WRONG && rename_vld_i) begin
            n_tag[dest_idx_i] = new_tag_i;
            n_rdy[dest_idx_i] = 1'b0;
        end
        for (int i = 0; i < N; i++) exp_bak[i*EW +: EW] = {n_rdy[i], n_tag[i]};
        if (m_valid || rst) begin
            chk("bak_next", bak_mp_next_data_o, exp_bak);
            for (int i = 0; i < N; i++) begin
                m_tag[i] = n_tag[i];
                m_rdy[i] = n_rdy[i];
            end
            m_valid = 1'b1;
        end
    end

    task automatic idle();
        rename_vld_i     = 1'b0;
        dest_idx_i       = '0;
        new_tag_i        = '0;
        src1_idx_i       = '0;
        src2_idx_i       = '0;
        cdb_vld_i        = 1'b0;
        cdb_tag_i        = '0;
        br_state_i       = '0;
        rc_mt_all_data_i = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [N*EW-1:0] snap;
        int k;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);

        // Reset image visible on checkpoint output while rst is held.
        #1;
        sample();
        chk("rst_bak_image", bak_mp_next_data_o, ident_image());

        // Identity mapping after reset.
        next_cycle(); rst = 1'b0;
        src1_idx_i = 5; dest_idx_i = 5;
        sample();
        chk("rst_src1_tag5", src1_tag_o, 6'd5);
        chk("rst_src1_rdy5", src1_rdy_o, 1'b1);
        chk("rst_old_tag5", old_tag_o, 6'd5);

        // Rename 3 -> 40, then read it, then CDB 40 forward, then entry ready.
        next_cycle(); rename_vld_i = 1'b1; dest_idx_i = 3; new_tag_i = 40;
        sample();
        chk("ren3_bak", bak_mp_next_data_o[3*EW +: EW], {1'b0, 6'd40});
        next_cycle(); src1_idx_i = 3;
        sample();
        chk("ren3_tag", src1_tag_o, 6'd40);
        chk("ren3_rdy0", src1_rdy_o, 1'b0);
        next_cycle(); src1_idx_i = 3; cdb_vld_i = 1'b1; cdb_tag_i = 40;
        sample();
        chk("ren3_cdb_fwd", src1_rdy_o, 1'b1);
        next_cycle(); src1_idx_i = 3;
        sample();
        chk("ren3_rdy_reg", src1_rdy_o, 1'b1);

        // Source equal to destination reads the old mapping.
        next_cycle(); rename_vld_i = 1'b1; dest_idx_i = 7; new_tag_i = 50; src1_idx_i = 7;
        sample();
        chk("byp_src1_tag", src1_tag_o, 6'd7);
        chk("byp_old_tag", old_tag_o, 6'd7);
        chk("byp_bak7", bak_mp_next_data_o[7*EW +: EW], {1'b0, 6'd50});

        // Rename overrides same-cycle CDB on that entry.
        next_cycle(); rename_vld_i = 1'b1; dest_idx_i = 2; new_tag_i = 33;
        next_cycle(); rename_vld_i = 1'b1; dest_idx_i = 2; new_tag_i = 41;
        cdb_vld_i = 1'b1; cdb_tag_i = 33;
        sample();
        chk("ovr_bak2", bak_mp_next_data_o[2*EW +: EW], {1'b0, 6'd41});
        next_cycle(); src1_idx_i = 2;
        sample();
        chk("ovr_tag2", src1_tag_o, 6'd41);
        chk("ovr_rdy2", src1_rdy_o, 1'b0);

        // Mispredict: snapshot load, CDB applied to loaded value, rename dropped.
        snap = ident_image();
        snap[4*EW +: EW] = {1'b0, 6'd45};
        next_cycle(); br_state_i = WRONG; rc_mt_all_data_i = snap;
        cdb_vld_i = 1'b1; cdb_tag_i = 45; rename_vld_i = 1'b1; dest_idx_i = 4; new_tag_i = 12;
        sample();
        chk("mp_bak4", bak_mp_next_data_o[4*EW +: EW], {1'b1, 6'd45});
        next_cycle(); src1_idx_i = 4; src2_idx_i = 3;
        sample();
        chk("mp_tag4", src1_tag_o, 6'd45);
        chk("mp_rdy4", src1_rdy_o, 1'b1);
        chk("mp_tag3", src2_tag_o, 6'd3);

        // Reset during rename and recovery wins.
        next_cycle(); rst = 1'b1; rename_vld_i = 1'b1; dest_idx_i = 9; new_tag_i = 60;
        br_state_i = WRONG; rc_mt_all_data_i = '0; cdb_vld_i = 1'b1; cdb_tag_i = 0;
        sample();
        chk("rstmix_bak", bak_mp_next_data_o, ident_image());
        next_cycle(); rst = 1'b0; src1_idx_i = 9; src2_idx_i = 4;
        sample();
        chk("rstmix_tag9", src1_tag_o, 6'd9);
        chk("rstmix_rdy9", src1_rdy_o, 1'b1);
        chk("rstmix_tag4", src2_tag_o, 6'd4);

        // Randomized traffic; the compare process checks every cycle.
        repeat (3000) begin
            next_cycle();
            rst          = ($urandom_range(0, 99) == 0);
            rename_vld_i = 1'($urandom_range(0, 1));
            dest_idx_i   = IW'($urandom_range(0, N-1));
            src1_idx_i   = ($urandom_range(0, 3) == 0) ? dest_idx_i : IW'($urandom_range(0, N-1));
            src2_idx_i   = IW'($urandom_range(0, N-1));
            new_tag_i    = TW'($urandom);
            cdb_vld_i    = 1'($urandom_range(0, 1));
            k            = int'($urandom_range(0, N-1));
            cdb_tag_i    = ($urandom_range(0, 3) != 0) ? m_tag[k] : TW'($urandom);
            br_state_i   = ($urandom_range(0, 15) == 0) ? WRONG : BW'($urandom_range(0, 2));
            for (int i = 0; i < N; i++) rc_mt_all_data_i[i*EW +: EW] = EW'($urandom);
        end

        next_cycle(); rst = 1'b0;
        sample();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
